// File: rtl/writeback_ctrl_if.sv
// Writeback controller bus: execute results, load returns, load issue,
// decode operand hazard query and the one-hot register-bank write port.
interface writeback_ctrl_if;
    logic        exe_we;
    logic [4:0]  exe_rd;
    logic [31:0] exe_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        hazard;
    logic [31:1] addrw;
    logic [31:0] wdata;

    modport master (
        output exe_we, exe_rd, exe_data,
        output ld_valid, ld_rd, ld_data,
        output issue_en, issue_rd,
        output rs1, rs2, rd,
        input  ld_ready, hazard, addrw, wdata
    );

    modport slave (
        input  exe_we, exe_rd, exe_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_en, issue_rd,
        input  rs1, rs2, rd,
        output ld_ready, hazard, addrw, wdata
    );
endinterface

// File: rtl/writeback_ctrl.sv
// Writeback controller: merges execute results with queued load returns onto
// the one-hot register-bank write port, and keeps a pending-load scoreboard
// that drives the decode hazard stall.
module writeback_ctrl (
    input  logic              clk,
    input  logic              reset,
    writeback_ctrl_if.slave   bus
);

    logic [4:0]  fifo_rd_q   [2];
    logic [4:0]  fifo_rd_d   [2];
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_data_d [2];
    logic        head_q;
    logic        head_d;
    logic        tail_q;
    logic        tail_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [31:1] pending_q;
    logic [31:1] pending_d;

    logic        exe_wr_s;
    logic        ready_s;
    logic        push_s;
    logic        pop_s;
    logic [4:0]  head_rd_s;
    logic [31:0] head_data_s;

    // Register index to one-hot write enable over x1..x31; x0 maps to nothing.
    function automatic logic [31:1] onehot(input logic [4:0] idx);
        logic [31:1] res;
        for (int i = 1; i < 32; i++) begin
            res[i] = (idx == 5'(i));
        end
        return res;
    endfunction

    // Scoreboard lookup with x0 always reading as not pending.
    function automatic logic pend_at(input logic [31:1] pend, input logic [4:0] idx);
        logic res;
        res = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (idx == 5'(i)) begin
                res = pend[i];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Handshake decisions: exe owns the port when it targets a real register,
    // otherwise the FIFO head drains; full never accepts, even while popping.
    always_comb begin
        head_rd_s   = fifo_rd_q[head_q];
        head_data_s = fifo_data_q[head_q];
        exe_wr_s    = bus.exe_we && (bus.exe_rd != 5'd0);
        ready_s     = reset && (count_q != 2'd2);
        push_s      = bus.ld_valid && ready_s && (bus.ld_rd != 5'd0);
        pop_s       = reset && !exe_wr_s && (count_q != 2'd0);
    end

    // Write port, ready and hazard outputs; all forced quiet while in reset.
    always_comb begin
        bus.ld_ready = ready_s;
        bus.hazard   = reset && (pend_at(pending_q, bus.rs1) |
                                 pend_at(pending_q, bus.rs2) |
                                 pend_at(pending_q, bus.rd));
        if (!reset) begin
            bus.addrw = 31'd0;
            bus.wdata = 32'd0;
        end else if (exe_wr_s) begin
            bus.addrw = onehot(bus.exe_rd);
            bus.wdata = bus.exe_data;
        end else if (count_q != 2'd0) begin
            bus.addrw = onehot(head_rd_s);
            bus.wdata = head_data_s;
        end else begin
            bus.addrw = 31'd0;
            bus.wdata = 32'd0;
        end
    end

    // Next FIFO contents, pointers and count.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        head_d      = head_q ^ pop_s;
        tail_d      = tail_q ^ push_s;
        if (push_s) begin
            fifo_rd_d[tail_q]   = bus.ld_rd;
            fifo_data_d[tail_q] = bus.ld_data;
        end else begin
            fifo_rd_d[tail_q]   = fifo_rd_q[tail_q];
            fifo_data_d[tail_q] = fifo_data_q[tail_q];
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next scoreboard: pop clears the head's bit, a same-cycle issue re-sets it.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < 32; i++) begin
            if (bus.issue_en && (bus.issue_rd == 5'(i))) begin
                pending_d[i] = 1'b1;
            end else if (pop_s && (head_rd_s == 5'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // State registers; reset discards queued loads and all pending bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_rd_q   <= '{5'd0, 5'd0};
            fifo_data_q <= '{32'd0, 32'd0};
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            pending_q   <= 31'd0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
        end
    end

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Writeback controller and load scoreboard that drives the one-hot write port of the 32×32 register bank. It merges single-cycle execute results with out-of-order-timed load returns through a 2-entry FIFO. It suppresses x0 writes and tracks registers with outstanding loads, so that decode stalls on RAW/WAW hazards until the value has been written.

## Interface
- No parameters; data width 32, register count 32 (x0 constant zero).
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears FIFO and scoreboard.
- exe_we  in  1  execute result valid this cycle; never back-pressured.
- exe_rd  in  5  execute destination register.
- exe_data  in  32  execute result.
- ld_valid  in  1  load return valid.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- ld_ready  out  1  FIFO can accept a load return; transfer on ld_valid && ld_ready.
- issue_en  in  1  decode issues a load this cycle.
- issue_rd  in  5  destination of the issued load.
- rs1, rs2, rd  in  5 each  operands and destination of the instruction in decode.
- hazard  out  1  decode must stall.
- addrw  out  31 (bits 31:1)  one-hot register-bank write enable; all zero means no write.
- wdata  out  32  register-bank write data.

## Operation
- FIFO: 2 entries of {rd[4:0], data[31:0]}, with head/tail pointers and count 0..2. In-order, no bypass: a load always spends at least one cycle in the FIFO.
- Push: ld_valid && ld_ready && ld_rd != 0. A load with ld_rd == 0 is handshaken (ld_ready honoured) and dropped.
- ld_ready = (count < 2). Full means not ready, even if a pop occurs in the same cycle.
- Write-port selection, combinational, each cycle:
  - If exe_we && exe_rd != 0: addrw = onehot(exe_rd), wdata = exe_data. The FIFO holds.
  - Else if count > 0: addrw = onehot(head.rd), wdata = head.data. Head is popped at the clock edge.
  - Else addrw = 0. wdata is don't-care; drive 0.
- exe_we with exe_rd == 0 writes nothing and does not block the FIFO pop.
- Push and pop may occur in the same cycle (count unchanged) when count is 1, or when count is 0 with a push only.
- Scoreboard: pending[31:1] register.
  - Set bit issue_rd on issue_en && issue_rd != 0.
  - Clear bit head.rd on FIFO pop.
  - Same-cycle set and clear of the same bit: set wins.
- hazard = pending[rs1] | pending[rs2] | pending[rd], with index 0 reading as 0. Combinational from registered pending only.
- Protocol, checked by bench assertions:
  - issue_en never targets a pending register.
  - exe_we never targets a pending register.
  - Every ld_valid corresponds to a pending register.
- Exe has strict priority. A load can starve under continuous exe writes; this is accepted because the pipeline issues at most one instruction per cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by upstream logic) clears count and pointers to 0 and pending to 0.
- While reset is low: ld_ready = 0, addrw = 0, wdata = 0, hazard = 0.
- Reset mid-operation discards FIFO contents and pending bits. No partial write is emitted.
- Exe write latency is 0: addrw is asserted in the same cycle, and the register bank captures it at that edge.
- Load write latency is at least 1 cycle after the handshake, plus 1 cycle per blocking exe write.
- pending clears at the pop edge, so hazard drops the cycle after the register-bank write. The register bank then returns the new value.
- issue_en at edge N raises hazard for that register from cycle N+1.

## Test plan
- Reset: hold reset low with ld_valid = 1 and exe_we = 1, exe_rd = 5 → ld_ready = 0, addrw = 0, hazard = 0. Release → ld_ready = 1.
- Exe write: exe_we = 1, exe_rd = 7, exe_data = 0xDEADBEEF → same cycle addrw = 0x40 (bit 7), wdata = 0xDEADBEEF. exe_rd = 0 → addrw = 0.
- Load path and scoreboard: issue_rd = 3; next cycle rs1 = 3 → hazard = 1. Return ld_rd = 3, data 0x12345678 → next cycle addrw bit 3, wdata = 0x12345678. Following cycle hazard = 0.
- Priority/backpressure: push loads to x4 and x5 on consecutive cycles while exe_we writes x9 for 3 cycles → count reaches 2 and ld_ready = 0. x4 then x5 are written in order after the exe writes stop. No write is lost or duplicated.
- Simultaneous push/pop: count = 1 (x6 queued), no exe, push x8 → x6 written, count stays 1, x8 written next cycle.
- Set-wins: pop of x10 in the same cycle as issue_en, issue_rd = 10 → pending[10] = 1 afterwards, and hazard with rs2 = 10 stays 1.
